// File: rtl/rs_syndrome_calc.sv
// RS(N,K) syndrome calculator over GF(2^5) (x^5+x^2+1): Horner evaluation of the
// received polynomial at alpha^1..alpha^2T, one symbol per clock, result held until acked.

module gfadder (
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [4:0] s
);
    assign s = a ^ b;
endmodule

// Multiply by a fixed field element; unrolls to a small XOR network.
module lcpmult #(
    parameter logic [4:0] COEF = 5'b00001
) (
    input  logic [4:0] a,
    output logic [4:0] p
);
    function automatic logic [4:0] mul_const(input logic [4:0] x_in);
        logic [4:0] x;
        logic [4:0] acc;
        x   = x_in;
        acc = '0;
        for (int i = 0; i < 5; i++) begin
            if (COEF[i]) acc = acc ^ x;
            x = {x[3:0], 1'b0} ^ (x[4] ? 5'b00101 : 5'b00000);
        end
        return acc;
    endfunction

    assign p = mul_const(a);
endmodule

module rs_syndrome_calc #(
    parameter int N = 31,
    parameter int T = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [4:0]      sym_in,
    input  logic            sym_valid,
    input  logic            sym_sop,
    output logic            sym_ready,
    output logic [10*T-1:0] syn_out,
    output logic            syn_valid,
    output logic            syn_zero,
    input  logic            syn_ack,
    output logic            sop_err
);
    localparam int         NSYN = 2 * T;
    localparam int         W    = 10 * T;
    localparam logic [4:0] LAST = 5'(N - 1);

    // alpha^j with the exponent reduced mod 31 (alpha has order 31).
    function automatic logic [4:0] alpha_pow(input int j);
        logic [4:0] p;
        int         e;
        e = j % 31;
        p = 5'b00001;
        for (int i = 0; i < 30; i++) begin
            if (i < e) p = {p[3:0], 1'b0} ^ (p[4] ? 5'b00101 : 5'b00000);
        end
        return p;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [4:0]   count_q;
    logic [W-1:0] acc_q;
    logic [W-1:0] acc_mul;
    logic [W-1:0] acc_step;
    logic [W-1:0] acc_seed;
    logic [W-1:0] out_src;

    logic beat;
    logic out_free;
    logic seed_en;
    logic step_en;
    logic count_clr;
    logic out_from_step;
    logic out_from_acc;
    logic err_d;

    // One multiplier/adder pair per syndrome; S_j occupies bits [5j-1:5j-5].
    for (genvar k = 0; k < NSYN; k++) begin : g_horner
        localparam logic [4:0] AJ = alpha_pow(k + 1);
        lcpmult #(.COEF(AJ)) u_mul (
            .a (acc_q[5*k +: 5]),
            .p (acc_mul[5*k +: 5])
        );
        gfadder u_add (
            .a (acc_mul[5*k +: 5]),
            .b (sym_in),
            .s (acc_step[5*k +: 5])
        );
    end

    assign acc_seed  = {NSYN{sym_in}};
    assign sym_ready = (state_q != ST_WAIT);
    assign beat      = sym_valid & sym_ready;
    assign out_free  = ~syn_valid | syn_ack;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        seed_en       = 1'b0;
        step_en       = 1'b0;
        count_clr     = 1'b0;
        out_from_step = 1'b0;
        out_from_acc  = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    if (sym_sop) begin
                        seed_en = 1'b1;
                        state_d = ST_ACCUM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    if (sym_sop) begin
                        seed_en = 1'b1;
                        err_d   = 1'b1;
                    end else if (count_q == LAST) begin
                        count_clr = 1'b1;
                        if (out_free) begin
                            out_from_step = 1'b1;
                            state_d       = ST_IDLE;
                        end else begin
                            // Output register still owned downstream: park the result in acc.
                            step_en = 1'b1;
                            state_d = ST_WAIT;
                        end
                    end else begin
                        step_en = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (syn_ack) begin
                    out_from_acc = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            if (seed_en)      acc_q <= acc_seed;
            else if (step_en) acc_q <= acc_step;

            if (seed_en)        count_q <= 5'd1;
            else if (count_clr) count_q <= '0;
            else if (step_en)   count_q <= count_q + 5'd1;
        end
    end

    assign out_src = out_from_acc ? acc_q : acc_step;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            syn_out   <= '0;
            syn_valid <= 1'b0;
            syn_zero  <= 1'b0;
            sop_err   <= 1'b0;
        end else begin
            sop_err <= err_d;
            if (out_from_step || out_from_acc) begin
                syn_out   <= out_src;
                syn_zero  <= ~|out_src;
                syn_valid <= 1'b1;
            end else if (syn_ack) begin
                syn_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Bench for rs_syndrome_calc: directed framing/back-pressure/reset cases plus random
// codewords, scored against direct polynomial evaluation via log/antilog tables.

module tb_rs_syndrome_calc;
    localparam int N = 31;
    localparam int T = 8;
    localparam int W = 10 * T;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [4:0]   sym_in;
    logic         sym_valid;
    logic         sym_sop;
    logic         sym_ready;
    logic [W-1:0] syn_out;
    logic         syn_valid;
    logic         syn_zero;
    logic         syn_ack = 1'b0;
    logic         sop_err;

    int n_checks = 0;
    int n_errors = 0;
    int sop_err_cnt = 0;
    int ack_mode = 0;  // 0 never, 1 always, 2 random, 3 one-shot then never

    logic [W:0] exp_q[$];
    logic [4:0] r[N];
    int         gf_exp[31];
    int         gf_log[32];

    rs_syndrome_calc #(.N(N), .T(T)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .sym_sop   (sym_sop),
        .sym_ready (sym_ready),
        .syn_out   (syn_out),
        .syn_valid (syn_valid),
        .syn_zero  (syn_zero),
        .syn_ack   (syn_ack),
        .sop_err   (sop_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic void init_tables();
        int e;
        e = 1;
        for (int k = 0; k < 31; k++) begin
            gf_exp[k] = e;
            gf_log[e] = k;
            e = e << 1;
            if ((e & 32) != 0) e = e ^ 'h25;
        end
    endfunction

    function automatic logic [4:0] gmul(input logic [4:0] a, input logic [4:0] b);
        if (a == 5'd0 || b == 5'd0) return 5'd0;
        return 5'(gf_exp[(gf_log[a] + gf_log[b]) % 31]);
    endfunction

    // S_j = sum_i r_i * alpha^(i*j), evaluated directly.
    function automatic logic [W:0] ref_result();
        logic [W-1:0] s;
        logic [4:0]   v;
        s = '0;
        for (int j = 1; j <= 2 * T; j++) begin
            v = 5'd0;
            for (int i = 0; i < N; i++) v = v ^ gmul(r[i], 5'(gf_exp[(i * j) % 31]));
            s[5*(j-1) +: 5] = v;
        end
        return {(s == '0), s};
    endfunction

    task automatic drive_beat(input logic [4:0] s, input logic sop);
        int guard;
        @(negedge clock);
        sym_in    = s;
        sym_sop   = sop;
        sym_valid = 1'b1;
        guard = 0;
        while (!sym_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (!sym_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL sym_ready_timeout: got 0 expected 1");
        end
        @(posedge clock);
        #1;
        sym_valid = 1'b0;
        sym_sop   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic send_cw(input int gap_pct);
        for (int idx = N - 1; idx >= 0; idx--) begin
            if ($urandom_range(0, 99) < gap_pct) idle_cycles($urandom_range(1, 3));
            drive_beat(r[idx], idx == N - 1);
        end
        exp_q.push_back(ref_result());
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) r[i] = 5'($urandom_range(0, 31));
    endtask

    task automatic fill_zero();
        for (int i = 0; i < N; i++) r[i] = 5'd0;
    endtask

    task automatic drain();
        int guard;
        ack_mode = 1;
        guard = 0;
        while ((exp_q.size() != 0 || syn_valid) && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    // Monitor: owns syn_ack, scores every consumed result.
    always @(negedge clock) begin : monitor
        logic [W:0] e;
        if (!reset_n) begin
            syn_ack = 1'b0;
        end else begin
            case (ack_mode)
                0: syn_ack = 1'b0;
                1: syn_ack = 1'b1;
                3: begin syn_ack = 1'b1; ack_mode = 0; end
                default: syn_ack = ($urandom_range(0, 99) < 60);
            endcase
            if (syn_valid && syn_ack) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: got %h expected none", {syn_zero, syn_out});
                end else begin
                    e = exp_q.pop_front();
                    check("syndromes", {syn_zero, syn_out}, e);
                end
            end
            if (sop_err) sop_err_cnt++;
        end
    end

    initial begin
        int c0;
        int guard;
        init_tables();
        reset_n   = 1'b0;
        sym_in    = 5'd0;
        sym_valid = 1'b0;
        sym_sop   = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_sym_ready", W'(sym_ready), W'(1));
        check("reset_syn_valid", W'(syn_valid), W'(0));
        check("reset_syn_out", {1'b0, syn_out}, '0);
        check("reset_syn_zero", W'(syn_zero), W'(0));
        check("reset_sop_err", W'(sop_err), W'(0));
        reset_n = 1'b1;

        // All-zero codeword
        ack_mode = 0;
        fill_zero();
        send_cw(0);
        check("zero_cw_valid", W'(syn_valid), W'(1));
        @(negedge clock);
        check("zero_cw_zero", W'(syn_zero), W'(1));
        check("zero_cw_out", {1'b0, syn_out}, '0);
        drain();

        // r_0 = 1: every syndrome is 1
        ack_mode = 0;
        fill_zero();
        r[0] = 5'b00001;
        send_cw(0);
        @(negedge clock);
        check("r0_out", {1'b0, syn_out}, {1'b0, {(2*T){5'b00001}}});
        check("r0_zero", W'(syn_zero), W'(0));
        drain();

        // r_1 = 1: S_j = alpha^j
        ack_mode = 0;
        fill_zero();
        r[1] = 5'b00001;
        send_cw(0);
        @(negedge clock);
        check("r1_low5", W'(syn_out[24:0]), W'({5'b00101, 5'b10000, 5'b01000, 5'b00100, 5'b00010}));
        drain();

        // Back-pressure: second codeword parks in WAIT
        ack_mode = 0;
        fill_random();
        send_cw(0);
        fill_random();
        send_cw(0);
        @(negedge clock);
        check("wait_sym_ready", W'(sym_ready), W'(0));
        check("wait_syn_valid", W'(syn_valid), W'(1));
        ack_mode = 3;
        guard = 0;
        while (exp_q.size() > 1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        @(negedge clock);
        check("after_ack_pending", W'(exp_q.size()), W'(1));
        check("after_ack_syn_valid", W'(syn_valid), W'(1));
        check("after_ack_sym_ready", W'(sym_ready), W'(1));
        drain();

        // Framing: sop reasserted at beat 10 restarts the codeword
        ack_mode = 2;
        c0 = sop_err_cnt;
        for (int b = 0; b < 10; b++) drive_beat(5'($urandom_range(0, 31)), b == 0);
        fill_random();
        send_cw(0);
        repeat (2) @(negedge clock);
        check("restart_sop_err_pulses", W'(sop_err_cnt - c0), W'(1));
        c0 = sop_err_cnt;
        drive_beat(5'($urandom_range(0, 31)), 1'b0);
        repeat (2) @(negedge clock);
        check("idle_nosop_sop_err", W'(sop_err_cnt - c0), W'(1));
        check("idle_nosop_ready", W'(sym_ready), W'(1));
        fill_random();
        send_cw(10);
        drain();

        // Asynchronous reset mid-codeword while a result is held
        ack_mode = 0;
        fill_random();
        send_cw(0);
        for (int b = 0; b < 15; b++) drive_beat(5'($urandom_range(0, 31)), b == 0);
        @(negedge clock);
        check("pre_reset_valid", W'(syn_valid), W'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_valid", W'(syn_valid), W'(0));
        check("async_reset_out", {1'b0, syn_out}, '0);
        check("async_reset_ready", W'(sym_ready), W'(1));
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        ack_mode = 2;
        fill_random();
        send_cw(0);
        drain();

        // Random codewords with gaps and random ack
        ack_mode = 2;
        for (int n = 0; n < 25; n++) begin
            if (n % 8 == 0) fill_zero();
            else fill_random();
            send_cw(20);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
